clock_disp_scan: RTL and testbench
==================================

Name: clock_disp_scan

Overview:
- Downstream display stage of the decade clock; consumes the binary time/date fields (sec, min, hour, day, month, year) produced by the counter.
- Converts each field to BCD with a sequential shift-add-3 engine and double-buffers the result.
- Drives a multiplexed 8-digit common-anode 7-segment display, selectable between a time page and a date page.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (50 MHz -> 1 kHz per digit); legal >= 2.
- CNT_W, $clog2(SCAN_DIV), width of the scan prescaler; derived, not overridden.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- upd_valid  in  1  field update request
- upd_ready  out  1  engine idle, update accepted when upd_valid && upd_ready
- sec_bin  in  6  seconds
- min_bin  in  6  minutes
- hour_bin  in  5  hours
- day_bin  in  5  day of month
- month_bin  in  4  month
- year_bin  in  14  year
- page  in  1  0 = time, 1 = date
- an_n  out  8  digit enables, active-low, one-hot-zero
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
- range_err  out  1  last committed update contained an out-of-range field

Behaviour:
- Reset values:
  - an_n = 8'hFE, seg_n = 7'h7F, upd_ready = 1, range_err = 0.
  - Display and shadow buffers are all BLANK; scan index = 0; prescaler = 0; FSM in IDLE.
- Conversion FSM states: IDLE, LOAD, SHIFT, COMMIT.
  - IDLE: upd_ready = 1. On acceptance, all six fields are snapshotted, field index = 0, next state LOAD.
  - LOAD (1 cycle): load the current field into the binary shift register, clear the BCD accumulator, set shift count to the field width (6, 6, 5, 5, 4, 14), and register the field range check (max 59, 59, 23, 31, 12, 9999). Month 0 and day 0 are also errors.
  - SHIFT (width cycles): each cycle, add 3 to every BCD nibble >= 5, then shift left 1, taking the binary MSB. When the count reaches 0:
    - store to the shadow buffer (2 digits; 4 for year), or DASH for every digit of the field if it failed the range check;
    - if field index < 5, increment it and go to LOAD, else go to COMMIT.
  - COMMIT (1 cycle): shadow -> display buffer atomically; range_err <= OR of the six field errors; go to IDLE.
- Latency:
  - upd_ready drops on the edge after acceptance.
  - Exactly 46 LOAD/SHIFT cycles plus 1 COMMIT; the display buffer updates and upd_ready returns on the 47th edge after acceptance.
- upd_valid while busy is ignored, with no queueing; field inputs are don't-care outside acceptance.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 continuously, independent of the FSM.
  - At terminal count the scan index increments modulo 8, wrapping 7 -> 0.
  - an_n and seg_n are registered and change on the same edge as the index, so the segment pattern always matches its anode.
- Page mapping (digit 7 = leftmost):
  - page 0: BLANK, BLANK, H1, H0, M1, M0, S1, S0.
  - page 1: D1, D0, Mo1, Mo0, Y3, Y2, Y1, Y0.
- page is sampled only when the index wraps 7 -> 0; a mid-frame toggle takes effect on the next frame.
- Segment codes:
  - 0-9: standard active-low patterns (0 = 7'h40, 8 = 7'h00).
  - BLANK = 7'h7F.
  - DASH = 7'h3F (g only).
- Reset asserted mid-conversion: immediate return to reset values; the partial shadow is discarded and the display buffer is cleared to BLANK.

Optional Feature:
- Macro: CLOCK_DISP_LZB_EN (leading-zero blanking).
- Defined:
  - H1 shows BLANK when the hour < 10.
  - D1 shows BLANK when the day < 10.
  - DASH fields are unaffected.
- Undefined: leading zeros are always displayed.
- Blanking is applied at COMMIT; latency is unchanged.

Decomposition:
- Package clock_disp_pkg holds:
  - 4-bit digit code typedef, with codes 0-9, BLANK = 4'hE, DASH = 4'hF;
  - field index enum;
  - per-field width and max-value constant arrays;
  - FSM state enum;
  - segment pattern constants.
- One sub-module, seg7_code_dec: combinational 4-bit digit code -> 7-bit active-low segments, including BLANK and DASH.
- FSM, BCD engine and scanner stay in clock_disp_scan.

Test Plan:
- Reset held, release -> an_n = FE, seg_n = 7F for the first slot, upd_ready = 1, range_err = 0; the index steps every SCAN_DIV clocks.
- Update 23:59:59, page 0 -> upd_ready low for 47 cycles; the scan frame shows BLANK, BLANK, 2, 3, 5, 9, 5, 9; range_err = 0.
- Update day 31, month 12, year 9999, page 1 -> 3, 1, 1, 2, 9, 9, 9, 9.
- Update sec = 60, year = 10000 -> seconds digits DASH, year digits DASH, others correct; range_err = 1. A following valid update clears range_err.
- upd_valid pulsed at cycle 10 of a conversion, then page toggled at digit 3 -> the second request is ignored; the page change appears only after the 7 -> 0 wrap.
- rst_n pulsed at cycle 20 of a conversion -> all outputs return to reset values, the display is BLANK, and upd_ready = 1. With CLOCK_DISP_LZB_EN, hour 5 shows BLANK, 5.

Source files
------------

// File: rtl/clock_disp_pkg.sv
// Shared types and constants for the clock display stage: digit codes,
// field tables for the BCD engine, FSM states and 7-segment patterns.
package clock_disp_pkg;

    typedef logic [3:0] digit_t;
    localparam digit_t DIG_BLANK = 4'hE;
    localparam digit_t DIG_DASH  = 4'hF;

    typedef enum logic [2:0] {
        F_SEC   = 3'd0,
        F_MIN   = 3'd1,
        F_HOUR  = 3'd2,
        F_DAY   = 3'd3,
        F_MONTH = 3'd4,
        F_YEAR  = 3'd5
    } field_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_COMMIT
    } state_t;

    localparam logic [3:0]  FIELD_W   [6] = '{4'd6, 4'd6, 4'd5, 4'd5, 4'd4, 4'd14};
    localparam logic [13:0] FIELD_MAX [6] = '{14'd59, 14'd59, 14'd23, 14'd31, 14'd12, 14'd9999};

    // Digit buffer layout: S0 S1 M0 M1 H0 H1 D0 D1 Mo0 Mo1 Y0 Y1 Y2 Y3
    localparam int NUM_SLOTS = 14;
    localparam field_t SLOT_FIELD [NUM_SLOTS] = '{
        F_SEC, F_SEC, F_MIN, F_MIN, F_HOUR, F_HOUR, F_DAY, F_DAY,
        F_MONTH, F_MONTH, F_YEAR, F_YEAR, F_YEAR, F_YEAR};
    localparam int SLOT_POS [NUM_SLOTS] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 2, 3};

    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next bit.
    function automatic logic [15:0] bcd_step(input logic [15:0] bcd, input logic bit_in);
        logic [15:0] adj;
        adj = bcd;
        for (int n = 0; n < 4; n++) begin
            if (bcd[4*n +: 4] >= 4'd5) begin
                adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
            end
        end
        return {adj[14:0], bit_in};
    endfunction

endpackage

// File: rtl/seg7_code_dec.sv
// Digit code to active-low {g,f,e,d,c,b,a} segment pattern; codes 10..14 blank.
module seg7_code_dec
    import clock_disp_pkg::*;
(
    input  digit_t     code,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        if (code <= 4'd9) begin
            seg_n = SEG_DIGIT[code];
        end else if (code == DIG_DASH) begin
            seg_n = SEG_DASH;
        end
    end

endmodule

// File: rtl/clock_disp_scan.sv
// Clock display stage: sequential BCD conversion into a double buffer and an
// 8-digit multiplexed scan. Define CLOCK_DISP_LZB_EN for leading-zero blanking.
module clock_disp_scan
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [5:0]  sec_bin,
    input  logic [5:0]  min_bin,
    input  logic [4:0]  hour_bin,
    input  logic [4:0]  day_bin,
    input  logic [3:0]  month_bin,
    input  logic [13:0] year_bin,
    input  logic        page,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        range_err
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    state_t      state_reg;
    field_t      fld_reg;
    logic [5:0]  sec_reg, min_reg;
    logic [4:0]  hour_reg, day_reg;
    logic [3:0]  month_reg;
    logic [13:0] year_reg;
    logic [13:0] bin_reg;
    logic [15:0] bcd_reg;
    logic [15:0] bcd_next;
    logic [3:0]  cnt_reg;
    logic        cur_err_reg;
    logic [5:0]  err_reg;
    logic        upd_ready_reg;
    logic        range_err_reg;
    digit_t      shadow_reg [NUM_SLOTS];
    digit_t      disp_reg   [NUM_SLOTS];
    logic [13:0] field_val;

    always_comb begin
        field_val = 14'd0;
        case (fld_reg)
            F_SEC:   field_val = {8'd0, sec_reg};
            F_MIN:   field_val = {8'd0, min_reg};
            F_HOUR:  field_val = {9'd0, hour_reg};
            F_DAY:   field_val = {9'd0, day_reg};
            F_MONTH: field_val = {10'd0, month_reg};
            F_YEAR:  field_val = year_reg;
            default: field_val = 14'd0;
        endcase
    end

    assign bcd_next = bcd_step(bcd_reg, bin_reg[13]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            fld_reg       <= F_SEC;
            sec_reg       <= '0;
            min_reg       <= '0;
            hour_reg      <= '0;
            day_reg       <= '0;
            month_reg     <= '0;
            year_reg      <= '0;
            bin_reg       <= '0;
            bcd_reg       <= '0;
            cnt_reg       <= '0;
            cur_err_reg   <= 1'b0;
            err_reg       <= '0;
            upd_ready_reg <= 1'b1;
            range_err_reg <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow_reg[i] <= DIG_BLANK;
                disp_reg[i]   <= DIG_BLANK;
            end
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (upd_valid) begin
                        sec_reg       <= sec_bin;
                        min_reg       <= min_bin;
                        hour_reg      <= hour_bin;
                        day_reg       <= day_bin;
                        month_reg     <= month_bin;
                        year_reg      <= year_bin;
                        fld_reg       <= F_SEC;
                        upd_ready_reg <= 1'b0;
                        state_reg     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Left-align the field so the MSB always leaves from bit 13.
                    bin_reg     <= field_val << (4'd14 - FIELD_W[fld_reg]);
                    bcd_reg     <= '0;
                    cnt_reg     <= FIELD_W[fld_reg];
                    cur_err_reg <= (field_val > FIELD_MAX[fld_reg]) ||
                                   (((fld_reg == F_DAY) || (fld_reg == F_MONTH)) && (field_val == 14'd0));
                    state_reg   <= S_SHIFT;
                end
                S_SHIFT: begin
                    bcd_reg <= bcd_next;
                    bin_reg <= bin_reg << 1;
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (SLOT_FIELD[i] == fld_reg) begin
                                shadow_reg[i] <= cur_err_reg ? DIG_DASH : bcd_next[4*SLOT_POS[i] +: 4];
                            end
                        end
                        err_reg[fld_reg] <= cur_err_reg;
                        if (fld_reg == F_YEAR) begin
                            state_reg <= S_COMMIT;
                        end else begin
                            fld_reg   <= field_t'(fld_reg + 3'd1);
                            state_reg <= S_LOAD;
                        end
                    end
                end
                S_COMMIT: begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        disp_reg[i] <= shadow_reg[i];
                    end
`ifdef CLOCK_DISP_LZB_EN
                    if (shadow_reg[5] == 4'd0) disp_reg[5] <= DIG_BLANK;
                    if (shadow_reg[7] == 4'd0) disp_reg[7] <= DIG_BLANK;
`endif
                    range_err_reg <= |err_reg;
                    upd_ready_reg <= 1'b1;
                    state_reg     <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign upd_ready = upd_ready_reg;
    assign range_err = range_err_reg;

    // Scanner: free-running prescaler, anode and segments latched together.
    logic [CNT_W-1:0] presc_reg;
    logic [2:0]       idx_reg;
    logic [2:0]       idx_next;
    logic             page_reg;
    logic             page_next;
    logic [7:0]       an_n_reg;
    logic [6:0]       seg_n_reg;
    digit_t           scan_digit;
    logic [6:0]       scan_seg;

    assign idx_next  = idx_reg + 3'd1;
    assign page_next = (idx_reg == 3'd7) ? page : page_reg;

    always_comb begin
        scan_digit = DIG_BLANK;
        if (!page_next) begin
            case (idx_next)
                3'd0:    scan_digit = disp_reg[0];
                3'd1:    scan_digit = disp_reg[1];
                3'd2:    scan_digit = disp_reg[2];
                3'd3:    scan_digit = disp_reg[3];
                3'd4:    scan_digit = disp_reg[4];
                3'd5:    scan_digit = disp_reg[5];
                default: scan_digit = DIG_BLANK;
            endcase
        end else begin
            case (idx_next)
                3'd0:    scan_digit = disp_reg[10];
                3'd1:    scan_digit = disp_reg[11];
                3'd2:    scan_digit = disp_reg[12];
                3'd3:    scan_digit = disp_reg[13];
                3'd4:    scan_digit = disp_reg[8];
                3'd5:    scan_digit = disp_reg[9];
                3'd6:    scan_digit = disp_reg[6];
                default: scan_digit = disp_reg[7];
            endcase
        end
    end

    seg7_code_dec u_seg7_code_dec (
        .code  (scan_digit),
        .seg_n (scan_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            idx_reg   <= '0;
            page_reg  <= 1'b0;
            an_n_reg  <= 8'hFE;
            seg_n_reg <= SEG_BLANK;
        end else if (presc_reg == CNT_LAST) begin
            presc_reg <= '0;
            idx_reg   <= idx_next;
            page_reg  <= page_next;
            an_n_reg  <= ~(8'b1 << idx_next);
            seg_n_reg <= scan_seg;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    assign an_n  = an_n_reg;
    assign seg_n = seg_n_reg;

endmodule

// File: tb/tb_clock_disp_scan.sv
// Self-checking bench for clock_disp_scan: vector table of updates, scoreboarded
// scan frames, plus busy-request, page-toggle and mid-conversion reset sequences.
module tb_clock_disp_scan;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [5:0]  sec_bin = '0;
    logic [5:0]  min_bin = '0;
    logic [4:0]  hour_bin = '0;
    logic [4:0]  day_bin = '0;
    logic [3:0]  month_bin = '0;
    logic [13:0] year_bin = '0;
    logic        page = 1'b0;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        range_err;

    always #5 clk = ~clk;

    clock_disp_scan #(.SCAN_DIV(SD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .sec_bin   (sec_bin),
        .min_bin   (min_bin),
        .hour_bin  (hour_bin),
        .day_bin   (day_bin),
        .month_bin (month_bin),
        .year_bin  (year_bin),
        .page      (page),
        .an_n      (an_n),
        .seg_n     (seg_n),
        .range_err (range_err)
    );

    typedef struct {
        int          sec;
        int          min;
        int          hour;
        int          day;
        int          month;
        int          year;
        logic        pg;
        logic [31:0] dig;   // digit7..digit0 codes, E = blank, F = dash
        logic        err;
    } vec_t;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
    } exp_t;

`ifdef CLOCK_DISP_LZB_EN
    localparam logic [31:0] EXP_H5  = 32'hEEE50703;
    localparam logic [31:0] EXP_D5  = 32'hE5060007;
    localparam logic [31:0] EXP_D9  = 32'hE909FFFF;
`else
    localparam logic [31:0] EXP_H5  = 32'hEE050703;
    localparam logic [31:0] EXP_D5  = 32'h05060007;
    localparam logic [31:0] EXP_D9  = 32'h0909FFFF;
`endif

    exp_t       sb[$];
    vec_t       vecs[11];
    logic [6:0] seg_tab[16];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_fields(input vec_t v);
        sec_bin   = 6'(v.sec);
        min_bin   = 6'(v.min);
        hour_bin  = 5'(v.hour);
        day_bin   = 5'(v.day);
        month_bin = 4'(v.month);
        year_bin  = 14'(v.year);
    endtask

    task automatic scramble_fields();
        sec_bin   = 6'($urandom);
        min_bin   = 6'($urandom);
        hour_bin  = 5'($urandom);
        day_bin   = 5'($urandom);
        month_bin = 4'($urandom);
        year_bin  = 14'($urandom);
    endtask

    task automatic push_frame(input logic [31:0] dig);
        exp_t e;
        for (int s = 0; s < 8; s++) begin
            e.an  = ~(8'b1 << s);
            e.seg = seg_tab[dig[4*s +: 4]];
            sb.push_back(e);
        end
    endtask

    // Align to the first slot after a 7 -> 0 wrap, then compare 8 slots.
    task automatic check_frame(input string tag, input int toggle_slot, input logic new_pg);
        logic [7:0] prev;
        bit         ok;
        exp_t       e;
        ok   = 1'b0;
        prev = an_n;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (an_n == 8'hFE && prev == 8'h7F) ok = 1'b1;
            else prev = an_n;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s frame_sync: no digit wrap seen, required within 200 cycles", tag);
            sb.delete();
            return;
        end
        for (int s = 0; s < 8; s++) begin
            if (sb.size() == 0) break;
            e = sb.pop_front();
            check($sformatf("%s an_n slot%0d", tag, s), 32'(an_n), 32'(e.an));
            check($sformatf("%s seg_n slot%0d", tag, s), 32'(seg_n), 32'(e.seg));
            if (s == toggle_slot) page = new_pg;
            repeat (SD) @(negedge clk);
        end
    endtask

    task automatic do_update(input vec_t v, input int pulse_at, output int lat);
        int w;
        w = 0;
        while (!upd_ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        check("ready_before_update", 32'(upd_ready), 32'd1);
        drive_fields(v);
        page      = v.pg;
        upd_valid = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        scramble_fields();
        lat = 0;
        while (!upd_ready && lat < 200) begin
            lat++;
            if (lat == pulse_at) begin
                sec_bin   = 6'd1;
                min_bin   = 6'd2;
                hour_bin  = 5'd3;
                upd_valid = 1'b1;
            end else begin
                upd_valid = 1'b0;
            end
            @(negedge clk);
        end
        upd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        do_update(v, -1, lat);
        $display("%s: latency %0d range_err %0b page %0b digits %h", tag, lat, range_err, v.pg, v.dig);
        check({tag, " latency"}, 32'(lat), 32'd47);
        check({tag, " range_err"}, 32'(range_err), 32'(v.err));
        push_frame(v.dig);
        check_frame(tag, -1, v.pg);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " an_n"}, 32'(an_n), 32'h0000_00FE);
        check({tag, " seg_n"}, 32'(seg_n), 32'h0000_007F);
        check({tag, " upd_ready"}, 32'(upd_ready), 32'd1);
        check({tag, " range_err"}, 32'(range_err), 32'd0);
    endtask

    // Called on the negedge where rst_n was released: slot 0 lasts SD clocks.
    task automatic check_release(input string tag);
        for (int k = 0; k < SD - 1; k++) begin
            @(negedge clk);
            check($sformatf("%s hold%0d an_n", tag, k), 32'(an_n), 32'h0000_00FE);
        end
        @(negedge clk);
        check({tag, " step an_n"}, 32'(an_n), 32'h0000_00FD);
        check({tag, " step seg_n"}, 32'(seg_n), 32'h0000_007F);
    endtask

    initial begin
        vec_t vb;
        int   lat;
        int   lows;

        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F};
        vecs[0]  = '{59, 59, 23,  1,  1,  2000, 1'b0, 32'hEE235959, 1'b0};
        vecs[1]  = '{56, 34, 12, 31, 12,  9999, 1'b1, 32'h31129999, 1'b0};
        vecs[2]  = '{60,  7, 14, 15,  3, 10000, 1'b0, 32'hEE1407FF, 1'b1};
        vecs[3]  = '{60,  7, 14, 15,  3, 10000, 1'b1, 32'h1503FFFF, 1'b1};
        vecs[4]  = '{ 0,  0, 10,  1,  1,     0, 1'b0, 32'hEE100000, 1'b0};
        vecs[5]  = '{ 1,  1, 11, 20,  0,  2024, 1'b1, 32'h20FF2024, 1'b1};
        vecs[6]  = '{ 1,  1, 11, 32, 13,     1, 1'b1, 32'hFFFF0001, 1'b1};
        vecs[7]  = '{ 0,  0, 24,  1,  1,     1, 1'b0, 32'hEEFF0000, 1'b1};
        vecs[8]  = '{ 3,  7,  5,  1,  1,     1, 1'b0, EXP_H5,       1'b0};
        vecs[9]  = '{ 0,  0, 12,  5,  6,     7, 1'b1, EXP_D5,       1'b0};
        vecs[10] = '{ 0, 59,  0,  9,  9, 16383, 1'b1, EXP_D9,       1'b1};

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        check_release("release");

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Request while busy must be dropped, then a mid-frame page toggle.
        vb = '{5, 43, 21, 28, 2, 2031, 1'b0, 32'hEE214305, 1'b0};
        do_update(vb, 10, lat);
        $display("busy: latency %0d range_err %0b", lat, range_err);
        check("busy latency", 32'(lat), 32'd47);
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!upd_ready) lows++;
        end
        check("busy no_requeue", 32'(lows), 32'd0);
        push_frame(vb.dig);
        check_frame("busy", -1, 1'b0);
        push_frame(vb.dig);
        check_frame("toggle_old", 3, 1'b1);
        push_frame(32'h28022031);
        check_frame("toggle_new", -1, 1'b1);

        // Reset at cycle 20 of a conversion, with range_err set beforehand.
        run_vec(vecs[2], "pre_reset");
        drive_fields(vecs[0]);
        page      = 1'b0;
        upd_valid = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        repeat (19) @(negedge clk);
        check("midrst busy", 32'(upd_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        $display("midrst: reset pulsed during conversion");
        check_release("midrst_release");
        push_frame(32'hEEEEEEEE);
        check_frame("midrst_blank", -1, 1'b0);
        run_vec(vecs[8], "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
